// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier.
// The optional abort feature is selected with the BOOTH_ABORT_EN macro.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    // Counter width able to hold 0 .. w1-1; never narrower than one bit.
    function automatic int cntWidth(input int w1);
        return (w1 < 2) ? 1 : $clog2(w1);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: recode {Q0,q-1}, add/subtract M, then
// arithmetic right shift of {Acc,Q,q-1}. Purely combinational.
module booth_step #(
    parameter int W1 = 9
) (
    input  logic [W1:0]   acc_i,
    input  logic [W1-1:0] q_i,
    input  logic          qm1_i,
    input  logic [W1-1:0] m_i,
    output logic [W1:0]   acc_o,
    output logic [W1-1:0] q_o,
    output logic          qm1_o
);

    logic [W1:0] mExt;
    logic [W1:0] sum;

    // Acc carries one guard bit so that -M for M = -2^WIDTH stays representable.
    assign mExt = {m_i[W1-1], m_i};

    always_comb begin
        sum = acc_i;
        unique case ({q_i[0], qm1_i})
            2'b01:   sum = acc_i + mExt;
            2'b10:   sum = acc_i - mExt;
            default: sum = acc_i;
        endcase
    end

    assign acc_o = {sum[W1], sum[W1:1]};
    assign q_o   = {sum[0], q_i[W1-1:1]};
    assign qm1_o = q_i[0];

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier with start/valid handshake and
// per-operation signed/unsigned mode. Define BOOTH_ABORT_EN for the abort port.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef BOOTH_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               valid,
    output logic [2*WIDTH-1:0] Y
);

    localparam int W1 = WIDTH + 1;
    localparam int CW = cntWidth(W1);

    booth_state_t    state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W1-1:0]   m_q, m_d;
    logic [W1:0]     acc_q, acc_d;
    logic [W1-1:0]   qreg_q, qreg_d;
    logic            qm1_q, qm1_d;
    logic [2*WIDTH-1:0] y_q, y_d;

    logic [W1:0]     stepAcc;
    logic [W1-1:0]   stepQ;
    logic            stepQm1;
    logic [W1-1:0]   loadM, loadQ;
    logic            abortReq;

`ifdef BOOTH_ABORT_EN
    assign abortReq = abort;
`else
    assign abortReq = 1'b0;
`endif

    // Widen by one bit so the full unsigned range multiplies exactly.
    assign loadM = signed_mode ? {A[WIDTH-1], A} : {1'b0, A};
    assign loadQ = signed_mode ? {B[WIDTH-1], B} : {1'b0, B};

    booth_step #(.W1(W1)) u_step (
        .acc_i (acc_q),
        .q_i   (qreg_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .acc_o (stepAcc),
        .q_o   (stepQ),
        .qm1_o (stepQm1)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        acc_d   = acc_q;
        qreg_d  = qreg_q;
        qm1_d   = qm1_q;
        y_d     = y_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    m_d     = loadM;
                    qreg_d  = loadQ;
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (abortReq) begin
                    state_d = IDLE;
                end else begin
                    acc_d  = stepAcc;
                    qreg_d = stepQ;
                    qm1_d  = stepQm1;
                    cnt_d  = cnt_q + CW'(1);
                    // Low 2*WIDTH bits of {Acc,Q}; upper bits are pure sign extension.
                    if (cnt_q == CW'(W1 - 1)) begin
                        state_d = DONE;
                        y_d     = {stepAcc[WIDTH-2:0], stepQ};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            qreg_q  <= '0;
            qm1_q   <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            qreg_q  <= qreg_d;
            qm1_q   <= qm1_d;
            y_q     <= y_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign valid = (state_q == DONE);
    assign Y     = y_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed testbench for booth_mul_seq (WIDTH=8); the abort scenario is
// exercised only when BOOTH_ABORT_EN is defined.
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [7:0]  A;
    logic [7:0]  B;
`ifdef BOOTH_ABORT_EN
    logic        abort;
`endif
    logic        busy;
    logic        valid;
    logic [15:0] Y;

    int vecCount  = 0;
    int missCount = 0;
    int cycles;
    int validSeen;

    booth_mul_seq #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
`ifdef BOOTH_ABORT_EN
        .abort       (abort),
`endif
        .busy        (busy),
        .valid       (valid),
        .Y           (Y)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after an active edge; presents a start request for one edge.
    task automatic applyStimulus(input logic sm, input logic [7:0] a, input logic [7:0] b);
        signed_mode = sm;
        A           = a;
        B           = b;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!valid && n < 30);
    endtask

    task automatic runOp(input string tag, input logic sm, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] expY);
        int n;
        applyStimulus(sm, a, b);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        waitValid(n);
        checkOutput({tag, "_latency"}, 32'(n), 32'd9);
        checkOutput({tag, "_Y"}, 32'(Y), 32'(expY));
        @(posedge clk);
        #1;
        checkOutput({tag, "_validdrop"}, 32'(valid), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        A           = '0;
        B           = '0;
`ifdef BOOTH_ABORT_EN
        abort       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_valid", 32'(valid), 32'd0);
        checkOutput("reset_Y", 32'(Y), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        runOp("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000);
        runOp("s_m3x5",      1'b1, 8'hFD, 8'h05, 16'hFFF1);
        runOp("s_127xm128",  1'b1, 8'h7F, 8'h80, 16'hC080);
        runOp("u_255x255",   1'b0, 8'hFF, 8'hFF, 16'hFE01);
        runOp("u_0x200",     1'b0, 8'h00, 8'hC8, 16'h0000);
        runOp("u_128x2",     1'b0, 8'h80, 8'h02, 16'h0100);
        runOp("s_m1xm1",     1'b1, 8'hFF, 8'hFF, 16'h0001);
        runOp("u_200x3",     1'b0, 8'hC8, 8'h03, 16'h0258);

        // Second start three cycles into RUN must be ignored.
        applyStimulus(1'b1, 8'd10, 8'd10);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 8'd7, 8'd7);
        checkOutput("ignore_busy", 32'(busy), 32'd1);
        waitValid(cycles);
        checkOutput("ignore_latency", 32'(cycles), 32'd6);
        checkOutput("ignore_Y", 32'(Y), 32'h0064);

        // Back-to-back start while in DONE.
        applyStimulus(1'b1, 8'd12, 8'hFE);
        checkOutput("b2b_validdrop", 32'(valid), 32'd0);
        checkOutput("b2b_busy", 32'(busy), 32'd1);
        waitValid(cycles);
        checkOutput("b2b_latency", 32'(cycles), 32'd9);
        checkOutput("b2b_Y", 32'(Y), 32'hFFE8);
        @(posedge clk);
        #1;

`ifdef BOOTH_ABORT_EN
        applyStimulus(1'b0, 8'd50, 8'd50);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_valid", 32'(valid), 32'd0);
        validSeen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (valid) validSeen++;
        end
        checkOutput("abort_novalid", 32'(validSeen), 32'd0);
        checkOutput("abort_Yheld", 32'(Y), 32'hFFE8);
`endif

        // Asynchronous reset in the middle of an operation.
        applyStimulus(1'b0, 8'd9, 8'd9);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_valid", 32'(valid), 32'd0);
        checkOutput("midrst_Y", 32'(Y), 32'd0);
        #4;
        rst = 1'b0;
        validSeen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (valid) validSeen++;
        end
        checkOutput("midrst_novalid", 32'(validSeen), 32'd0);

        runOp("post_rst_s_m3x5", 1'b1, 8'hFD, 8'h05, 16'hFFF1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
